// File: rtl/allpass_coef_loader_if.sv
// ---------------------------------------------------------------------------
// allpass_coef_loader_if
//
// Purpose:
//   Valid/ready word stream that carries allpass coefficients, one signed
//   word per beat, into allpass_coef_loader.
//
// Signals:
//   s_valid  sender has a word on s_data
//   s_ready  loader can take a word this cycle
//   s_data   signed coefficient word (WIDTH bits)
//   s_last   marks the final word of a frame
//
// Modports:
//   master   the coefficient source (drives valid/data/last)
//   slave    the loader (drives ready)
// ---------------------------------------------------------------------------
interface allpass_coef_loader_if #(
  parameter int WIDTH = 16
);

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/allpass_coef_loader.sv
// ---------------------------------------------------------------------------
// allpass_coef_loader
//
// Purpose:
//   Serial-to-parallel coefficient loader for the allpass IIR section.
//   Words arrive one per handshake beat and are collected in shadow
//   registers. Only a frame of exactly N words (s_last on the N-th) is
//   copied to the parallel bus c, and that copy happens on a single clock
//   edge, so the filter never sees a half-updated coefficient set.
//   Short and long frames are discarded and flagged with an err pulse.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   s           coefficient stream (slave side of allpass_coef_loader_if)
//   c           committed coefficients, index g at [WIDTH*(g+1)-1 : WIDTH*g]
//   c_update    one-cycle pulse in the first cycle a new c is visible
//   err         one-cycle pulse after a malformed frame is detected
//   commit_cnt  number of successful commits, wraps 255 -> 0
// ---------------------------------------------------------------------------
module allpass_coef_loader #(
  parameter int WIDTH = 16,
  parameter int N     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  allpass_coef_loader_if.slave s,
  output logic [WIDTH*N-1:0]   c,
  output logic                 c_update,
  output logic                 err,
  output logic [7:0]           commit_cnt
);

  // idx must still be at least one bit wide when N == 1
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DROP   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDXW-1:0]  idx;
  logic [IDXW-1:0]  idx_nxt;
  logic [WIDTH-1:0] shadow [N];
  logic             ready_q;
  logic             accept;
  logic             shadow_we;
  logic             commit;
  logic             err_nxt;

  // s_ready comes straight from a flop so it never depends on s_valid;
  // it is low during reset and during the single COMMIT bubble.
  assign s.s_ready = ready_q;
  assign accept    = s.s_valid && ready_q;

  // Next-state logic. In LOAD every accepted word lands in the shadow
  // registers; s_last is then compared against the word position to spot
  // short frames (s_last too early) and long frames (no s_last on the N-th
  // word). A long frame parks in DROP, which swallows words silently until
  // the sender's s_last lets the loader resynchronise.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    shadow_we = 1'b0;
    commit    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_LOAD: begin
        if (accept) begin
          shadow_we = 1'b1;
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            if (s.s_last) begin
              state_nxt = ST_COMMIT;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = ST_DROP;
            end
          end else if (s.s_last) begin
            err_nxt = 1'b1;
            idx_nxt = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        commit    = 1'b1;
        idx_nxt   = '0;
        state_nxt = ST_LOAD;
      end
      ST_DROP: begin
        if (accept && s.s_last) begin
          idx_nxt   = '0;
          state_nxt = ST_LOAD;
        end
      end
      default: begin
        idx_nxt   = '0;
        state_nxt = ST_LOAD;
      end
    endcase
  end

  // State, index and the registered ready flag. ready_q looks one state
  // ahead so that it is already low for the whole COMMIT cycle and comes
  // back high on the same edge that leaves COMMIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_LOAD;
      idx     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      ready_q <= (state_nxt != ST_COMMIT);
    end
  end

  // Shadow registers collect the frame word by word; nothing downstream
  // sees them until the whole frame has been validated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int g = 0; g < N; g++) begin
        shadow[g] <= '0;
      end
    end else if (shadow_we) begin
      shadow[idx] <= s.s_data;
    end
  end

  // The committed bus and its status outputs. c is copied from all shadow
  // registers on one edge, and reset clears it immediately so a filter
  // never keeps running on coefficients from an abandoned frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c          <= '0;
      c_update   <= 1'b0;
      err        <= 1'b0;
      commit_cnt <= 8'd0;
    end else begin
      c_update <= commit;
      err      <= err_nxt;
      if (commit) begin
        for (int g = 0; g < N; g++) begin
          c[g*WIDTH +: WIDTH] <= shadow[g];
        end
        commit_cnt <= commit_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_allpass_coef_loader.sv
// ---------------------------------------------------------------------------
// tb_allpass_coef_loader
//
// Purpose:
//   Self-checking bench for allpass_coef_loader. Each well-formed frame
//   pushes its packed coefficient set onto a scoreboard queue when it is
//   driven; a monitor pops and compares whenever c_update fires, and also
//   watches that c never moves outside a commit and that pulses are one
//   cycle wide. Directed steps cover reset, normal, short, long,
//   back-to-back, gapped and mid-frame-reset cases.
// ---------------------------------------------------------------------------
module tb_allpass_coef_loader;

  localparam int WIDTH = 16;
  localparam int N     = 5;
  localparam int CW    = WIDTH * N;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] c;
  logic          c_update;
  logic          err;
  logic [7:0]    commit_cnt;

  allpass_coef_loader_if #(.WIDTH(WIDTH)) bus ();

  allpass_coef_loader #(.WIDTH(WIDTH), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (bus),
    .c          (c),
    .c_update   (c_update),
    .err        (err),
    .commit_cnt (commit_cnt)
  );

  always #5 clk = ~clk;

  int            checks    = 0;
  int            errors    = 0;
  int            bubbles   = 0;
  int            errPulses = 0;
  logic [7:0]    expCommits = 8'd0;
  logic [CW-1:0] expC = '0;
  logic [CW-1:0] expQ[$];
  logic [CW-1:0] prevC = '0;
  logic          prevCupd = 1'b0;
  logic          prevErr = 1'b0;

  // Single comparison point: every check in the bench goes through here
  task automatic checkOutput(input string tag, input logic [CW-1:0] obs,
                             input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one word and hold it until the loader takes it; returns 1 time
  // unit after the accepting edge with s_valid still high
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic l);
    int n;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    n = 0;
    while (!bus.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", CW'(bus.s_ready), CW'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a well-formed frame and record what it must commit
  task automatic sendFrame(input logic [CW-1:0] f, input bit gaps);
    expQ.push_back(f);
    expC       = f;
    expCommits = expCommits + 8'd1;
    for (int g = 0; g < N; g++) begin
      applyStimulus(f[g*WIDTH +: WIDTH], (g == N - 1));
      if (gaps && g != N - 1) idle($urandom_range(0, 2));
    end
  endtask

  task automatic waitCommit();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checkOutput("commit_timeout", CW'(expQ.size()), CW'(0));
    #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      if (!bus.s_ready) bubbles++;
      if (c_update) begin
        if (expQ.size() == 0) checkOutput("spurious_commit", CW'(c_update), CW'(0));
        else checkOutput("sb_c", c, expQ.pop_front());
        checkOutput("c_update_width", CW'(prevCupd), CW'(0));
      end else begin
        checkOutput("c_stable", c, prevC);
      end
      if (err) begin
        errPulses++;
        checkOutput("err_width", CW'(prevErr), CW'(0));
      end
    end
    prevC    = c;
    prevCupd = c_update;
    prevErr  = err;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0;
    int e0;
    logic [CW-1:0] f1;

    f1          = 80'h7FFF_0100_E000_2000_1000;
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", CW'(bus.s_ready), CW'(0));
    checkOutput("rst_c", c, '0);
    checkOutput("rst_c_update", CW'(c_update), CW'(0));
    checkOutput("rst_err", CW'(err), CW'(0));
    checkOutput("rst_commit_cnt", CW'(commit_cnt), CW'(0));
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_after_rst", CW'(bus.s_ready), CW'(1));

    // Frame 1 with exact commit timing
    $display("[TB] frame 1");
    b0 = bubbles;
    sendFrame(f1, 1'b0);
    idle(0);
    checkOutput("commit_bubble", CW'(bus.s_ready), CW'(0));
    checkOutput("c_before_commit", c, '0);
    @(posedge clk);
    #1;
    checkOutput("c_update_high", CW'(c_update), CW'(1));
    checkOutput("c_frame1", c, f1);
    checkOutput("ready_back", CW'(bus.s_ready), CW'(1));
    checkOutput("cnt_frame1", CW'(commit_cnt), CW'(1));
    @(posedge clk);
    #1;
    checkOutput("c_update_low", CW'(c_update), CW'(0));
    waitCommit();
    checkOutput("bubbles_frame1", CW'(bubbles - b0), CW'(1));

    // Short frame, then a valid frame
    $display("[TB] short frame");
    e0 = errPulses;
    applyStimulus(16'h0AAA, 1'b0);
    applyStimulus(16'h0BBB, 1'b0);
    applyStimulus(16'h0CCC, 1'b1);
    checkOutput("short_err", CW'(err), CW'(1));
    idle(1);
    checkOutput("short_err_low", CW'(err), CW'(0));
    checkOutput("short_c_hold", c, expC);
    checkOutput("short_cnt_hold", CW'(commit_cnt), CW'(expCommits));
    sendFrame(80'h0001_FFFF_8000_1234_ABCD, 1'b0);
    idle(0);
    waitCommit();
    checkOutput("short_err_count", CW'(errPulses - e0), CW'(1));
    checkOutput("cnt_frame2", CW'(commit_cnt), CW'(expCommits));

    // Long frame: err right after the fifth word, rest dropped
    $display("[TB] long frame");
    e0 = errPulses;
    for (int g = 0; g < 4; g++) applyStimulus(WIDTH'(16'h5100 + g), 1'b0);
    applyStimulus(16'h5104, 1'b0);
    checkOutput("long_err_timing", CW'(err), CW'(1));
    applyStimulus(16'h5105, 1'b0);
    checkOutput("drop_no_err", CW'(err), CW'(0));
    applyStimulus(16'h5106, 1'b1);
    idle(2);
    checkOutput("long_c_hold", c, expC);
    checkOutput("long_err_count", CW'(errPulses - e0), CW'(1));
    sendFrame(80'h1111_2222_3333_4444_5555, 1'b0);
    idle(0);
    waitCommit();
    checkOutput("cnt_after_long", CW'(commit_cnt), CW'(expCommits));

    // Back-to-back frames with s_valid held high
    $display("[TB] back-to-back");
    b0 = bubbles;
    e0 = errPulses;
    sendFrame(80'hA000_A001_A002_A003_A004, 1'b0);
    sendFrame(80'hB000_B001_B002_B003_B004, 1'b0);
    sendFrame(80'hC000_C001_C002_C003_C004, 1'b0);
    idle(0);
    waitCommit();
    idle(2);
    checkOutput("b2b_bubbles", CW'(bubbles - b0), CW'(3));
    checkOutput("b2b_c", c, 80'hC000_C001_C002_C003_C004);
    checkOutput("b2b_cnt", CW'(commit_cnt), CW'(expCommits));
    checkOutput("b2b_no_err", CW'(errPulses - e0), CW'(0));

    // Random valid gaps inside a frame
    $display("[TB] gapped frame");
    e0 = errPulses;
    sendFrame(80'hDEAD_BEEF_0F0F_F0F0_8001, 1'b1);
    idle(0);
    waitCommit();
    checkOutput("gap_c", c, 80'hDEAD_BEEF_0F0F_F0F0_8001);
    checkOutput("gap_no_err", CW'(errPulses - e0), CW'(0));

    // Reset in the middle of a frame
    $display("[TB] reset mid-frame");
    sendFrame({N{16'h0555}}, 1'b0);
    idle(0);
    waitCommit();
    checkOutput("pre_rst_c", c, {N{16'h0555}});
    applyStimulus(16'h7700, 1'b0);
    applyStimulus(16'h7701, 1'b0);
    applyStimulus(16'h7702, 1'b0);
    idle(0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_c_clear", c, '0);
    checkOutput("async_cnt_clear", CW'(commit_cnt), CW'(0));
    checkOutput("async_no_update", CW'(c_update), CW'(0));
    checkOutput("async_no_err", CW'(err), CW'(0));
    checkOutput("async_ready_low", CW'(bus.s_ready), CW'(0));
    expCommits = 8'd0;
    expC       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    e0 = errPulses;
    sendFrame(80'h0123_4567_89AB_CDEF_7654, 1'b0);
    idle(0);
    waitCommit();
    checkOutput("post_rst_c", c, 80'h0123_4567_89AB_CDEF_7654);
    checkOutput("post_rst_cnt", CW'(commit_cnt), CW'(1));
    checkOutput("post_rst_no_err", CW'(errPulses - e0), CW'(0));

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/allpass_coef_loader.md
# allpass_coef_loader

Serial-to-parallel coefficient loader for the `allpass` IIR section. It accepts N signed WIDTH-bit coefficients one word per handshake beat and builds them in shadow registers. Once a well-formed frame is complete, it commits all N coefficients to the packed parallel bus `c` in a single clock edge. The filter therefore never sees a partially updated coefficient set. Malformed frames are detected, discarded and flagged.

## Interface
- WIDTH, 16, bit width of each coefficient (matches filter WIDTH)
- N, 5, number of coefficients per frame (matches filter N)

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk
- s_valid  in  1  input word valid
- s_ready  out  1  loader can accept a word
- s_data  in  WIDTH  signed coefficient word; the first beat of a frame is index 0
- s_last  in  1  marks the final beat of a frame
- c  out  WIDTH*N  committed coefficients; index g occupies bits [WIDTH*(g+1)-1 : WIDTH*g]
- c_update  out  1  one-cycle pulse, high in the cycle in which the new `c` is first visible
- err  out  1  one-cycle pulse on frame-length error
- commit_cnt  out  8  count of successful commits, wraps 255 -> 0

## Operation
- A beat is accepted when s_valid && s_ready at a rising edge. s_data and s_last are ignored otherwise.
- Index counter idx ranges 0..N-1. An accepted beat in LOAD writes shadow[idx] and advances idx.
- States:
  - LOAD: s_ready = 1.
    - Accepted beat with idx == N-1 and s_last = 1: go to COMMIT.
    - Accepted beat with idx < N-1 and s_last = 1 (short frame): err pulse, idx <- 0, stay in LOAD, shadow contents are don't-care.
    - Accepted beat with idx == N-1 and s_last = 0 (long frame): err pulse, go to DROP.
  - COMMIT: s_ready = 0. At the next edge:
    - c <- shadow[0..N-1] as one atomic update;
    - c_update <- 1 for one cycle;
    - commit_cnt increments;
    - idx <- 0;
    - go to LOAD.
  - DROP: s_ready = 1. Accepted beats are discarded. An accepted beat with s_last = 1 sets idx <- 0 and returns to LOAD. No further err pulses are raised in DROP.
- `c` changes only in the COMMIT transition. Errors never modify `c` or commit_cnt.
- No arithmetic is performed; coefficients pass bit-exact, two's complement, unchanged.
- Reset values (reset asserted):
  - state = LOAD, idx = 0;
  - shadow = 0, c = 0;
  - c_update = 0, err = 0, commit_cnt = 0;
  - s_ready = 0 while reset is asserted, 1 from the first edge after release.
- Reset asserted mid-frame or during COMMIT: the frame is abandoned and `c` is cleared to 0 immediately (asynchronously). No c_update or err pulse results.
- N = 1: every accepted beat with s_last = 1 commits. A beat with s_last = 0 is a long-frame error.

## Timing
- Final beat accepted at edge E:
  - state = COMMIT during cycle E..E+1;
  - at edge E+1, c is updated and c_update = 1 (cycle E+1..E+2);
  - s_ready is back to 1 from E+1.
- Latency from the final beat to the new `c` is 1 cycle after acceptance, i.e. c is valid 2 edges after the beat is presented and accepted at E.
- Minimum frame period is N+1 cycles, because COMMIT inserts exactly one s_ready = 0 bubble per frame.
- err is registered: it is high for the cycle following the edge that accepted the offending beat.
- s_valid may stay high across the COMMIT bubble. The pending word is held by the sender and accepted at E+1 as index 0 of the next frame.
- s_ready depends only on state (registered). It never depends combinationally on s_valid.

## Test plan
- Reset, then a frame of 5 beats 0x1000, 0x2000, 0xE000, 0x0100, 0x7FFF with s_last on beat 4.
  - Required: c == {0x7FFF,0x0100,0xE000,0x2000,0x1000}; c_update high exactly 1 cycle; commit_cnt = 1; s_ready low exactly 1 cycle.
- Short frame: 3 beats with s_last on beat 2, then a valid 5-beat frame.
  - Required: err pulses once; c unchanged after the short frame; then c == the second frame; commit_cnt = 1.
- Long frame: 7 beats, s_last only on beat 6.
  - Required: err pulses once, 1 cycle after beat 4; beats 5 and 6 are dropped; c unchanged; the next 5-beat frame commits normally.
- Back-to-back: 3 frames with s_valid held high continuously.
  - Required: exactly one bubble per frame; commit_cnt = 3; c equals frame 3; each c_update is 1 cycle wide.
- Random s_valid gaps (about 50% duty) within a frame.
  - Required: same committed result as a gap-free frame; no spurious err.
- rst asserted after beat 2 of a frame with c previously = all 0x0555.
  - Required: c == 0 immediately (asynchronously); after release, a new 5-beat frame commits from index 0; commit_cnt = 1.
